bsm_mac_array: RTL and testbench

//  LANES-wide bit-serial multiply-accumulate engine; successor to the single-lane BSM multiplier.

---
 rtl/bsm_pkg.sv | 24 ++
 rtl/bsm_lane.sv | 113 +++++++++++
 rtl/bsm_mac_array.sv | 146 ++++++++++++++
 tb/tb_bsm_mac_array.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsm_pkg.sv
// Shared types and helpers for the bit-serial MAC array: FSM state encoding,
// operand-width clamping and the per-lane partial-product width.
package bsm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    OUT    = 2'd2
  } state_e;

  // A product of two max_w-bit operands, either of which may be signed,
  // always fits in 2*max_w+1 two's complement bits.
  function automatic int prod_width(input int max_w);
    return 2 * max_w + 1;
  endfunction

  // A zero width means one bit; anything wider than the datapath is cut down.
  function automatic int unsigned clamp_width(input int unsigned w, input int unsigned max_w);
    if (w == 0) return 1;
    if (w > max_w) return max_w;
    return w;
  endfunction

endpackage

// File: rtl/bsm_lane.sv
// One lane of the bit-serial MAC: builds A*B one bit column per beat and folds
// each finished product into the lane accumulator (saturating if BSM_MAC_SAT_EN).
module bsm_lane
  import bsm_pkg::*;
#(
  parameter int MAX_W = 16,
  parameter int ACC_W = 40,
  parameter int CW    = $clog2(MAX_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_beat_en,
  input  logic [CW-1:0]    i_beat,
  input  logic             i_last,
  input  logic             i_a_ext,
  input  logic             i_a_cap,
  input  logic             i_sign_a,
  input  logic             i_sign_b,
  input  logic             i_bit_a,
  input  logic             i_bit_b,
  output logic [ACC_W-1:0] o_acc,
  output logic             o_ovf
);

  localparam int PW = prod_width(MAX_W);

  logic [MAX_W-1:0]        r_acur;
  logic [MAX_W-1:0]        r_bcur;
  logic signed [PW-1:0]    r_p;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_a_msb;

  logic                    w_a;
  logic signed [PW-1:0]    w_t_ab;
  logic signed [PW-1:0]    w_t_ba;
  logic signed [PW-1:0]    w_t_sq;
  logic signed [PW-1:0]    w_p_next;
  logic signed [ACC_W-1:0] w_prod;
  logic signed [ACC_W-1:0] w_acc_next;

`ifdef BSM_MAC_SAT_EN
  logic signed [ACC_W:0]   w_sum;
  logic                    w_clamp;
  logic                    r_ovf;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first, so no latch is inferred.
    w_a    = i_a_ext ? (i_sign_a & r_a_msb) : i_bit_a;
    w_t_ab = w_a ? (PW'(r_bcur) << i_beat) : '0;
    w_t_ba = i_bit_b ? (PW'(r_acur) << i_beat) : '0;
    w_t_sq = (w_a & i_bit_b) ? (PW'(1) << {i_beat, 1'b0}) : '0;
    // The top column carries the negative weight of each signed operand's sign bit.
    if (i_last && i_sign_a) w_t_ab = -w_t_ab;
    if (i_last && i_sign_b) w_t_ba = -w_t_ba;
    if (i_last && (i_sign_a ^ i_sign_b)) w_t_sq = -w_t_sq;
    w_p_next = r_p + w_t_ab + w_t_ba + w_t_sq;
    w_prod   = ACC_W'(w_p_next);
`ifdef BSM_MAC_SAT_EN
    w_sum   = (ACC_W + 1)'(r_acc) + (ACC_W + 1)'(w_prod);
    w_clamp = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    if (!w_clamp)         w_acc_next = w_sum[ACC_W-1:0];
    else if (w_sum[ACC_W]) w_acc_next = {1'b1, {(ACC_W-1){1'b0}}};
    else                  w_acc_next = {1'b0, {(ACC_W-1){1'b1}}};
`else
    w_acc_next = r_acc + w_prod;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (!rst) begin
      r_acur  <= '0;
      r_bcur  <= '0;
      r_p     <= '0;
      r_acc   <= '0;
      r_a_msb <= 1'b0;
    end else if (i_clear) begin
      r_acur  <= '0;
      r_bcur  <= '0;
      r_p     <= '0;
      r_acc   <= '0;
      r_a_msb <= 1'b0;
    end else if (i_beat_en) begin
      if (i_a_cap) r_a_msb <= i_bit_a;
      if (i_last) begin
        r_acur <= '0;
        r_bcur <= '0;
        r_p    <= '0;
        r_acc  <= w_acc_next;
      end else begin
        r_acur <= r_acur | (MAX_W'(w_a) << i_beat);
        r_bcur <= r_bcur | (MAX_W'(i_bit_b) << i_beat);
        r_p    <= w_p_next;
      end
    end
  end

`ifdef BSM_MAC_SAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                r_ovf <= 1'b0;
    else if (i_clear)                        r_ovf <= 1'b0;
    else if (i_beat_en && i_last && w_clamp) r_ovf <= 1'b1;
  end
  assign o_ovf = r_ovf;
`else
  assign o_ovf = 1'b0;
`endif

  assign o_acc = r_acc;

endmodule

// File: rtl/bsm_mac_array.sv
// LANES-wide bit-serial multiply-accumulate engine: FSM, beat/product counters,
// latched job config and shared B extension. Define BSM_MAC_SAT_EN for saturation.
module bsm_mac_array
  import bsm_pkg::*;
#(
  parameter int MAX_W = 16,
  parameter int LANES = 4,
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(MAX_W+1)-1:0] wa,
  input  logic [$clog2(MAX_W+1)-1:0] wb,
  input  logic                       sign_a,
  input  logic                       sign_b,
  input  logic [CNT_W-1:0]           acc_len,
  input  logic                       abort,
  output logic                       busy,
  input  logic                       bit_valid,
  output logic                       bit_ready,
  input  logic [LANES-1:0]           bits_a,
  input  logic                       bit_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*ACC_W-1:0]     result,
  output logic [LANES-1:0]           overflow
);

  localparam int CW = $clog2(MAX_W + 1);

  state_e           r_state;
  logic             r_busy, r_bit_ready, r_out_valid;
  logic [CW-1:0]    r_wa, r_wb, r_maxw, r_beat;
  logic             r_sign_a, r_sign_b, r_b_msb;
  logic [CNT_W-1:0] r_acc_len, r_prod;

  logic [CW-1:0]    w_wa_c, w_wb_c;
  logic             w_accept, w_last, w_clear, w_prod_done;
  logic             w_a_ext, w_a_cap, w_b_ext, w_b_cap, w_bit_b;

  assign w_wa_c      = CW'(clamp_width(32'(wa), MAX_W));
  assign w_wb_c      = CW'(clamp_width(32'(wb), MAX_W));
  assign w_accept    = r_bit_ready & bit_valid & ~abort;
  assign w_last      = (r_beat == r_maxw - CW'(1));
  assign w_prod_done = (r_prod == r_acc_len - CNT_W'(1));
  assign w_clear     = abort | (start & (r_state == IDLE));
  assign w_a_ext     = (r_beat >= r_wa);
  assign w_a_cap     = (r_beat == r_wa - CW'(1));
  assign w_b_ext     = (r_beat >= r_wb);
  assign w_b_cap     = (r_beat == r_wb - CW'(1));
  // Beats past wb replay B's sign bit (or zero), shared by every lane.
  assign w_bit_b     = w_b_ext ? (r_sign_b & r_b_msb) : bit_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_bit_ready <= 1'b0;
      r_out_valid <= 1'b0;
      r_wa        <= '0;
      r_wb        <= '0;
      r_maxw      <= '0;
      r_beat      <= '0;
      r_sign_a    <= 1'b0;
      r_sign_b    <= 1'b0;
      r_b_msb     <= 1'b0;
      r_acc_len   <= '0;
      r_prod      <= '0;
    end else if (abort) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_bit_ready <= 1'b0;
      r_out_valid <= 1'b0;
      r_beat      <= '0;
      r_prod      <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_wa        <= w_wa_c;
          r_wb        <= w_wb_c;
          r_maxw      <= (w_wa_c > w_wb_c) ? w_wa_c : w_wb_c;
          r_sign_a    <= sign_a;
          r_sign_b    <= sign_b;
          r_acc_len   <= (acc_len == '0) ? CNT_W'(1) : acc_len;
          r_beat      <= '0;
          r_prod      <= '0;
          r_state     <= STREAM;
          r_busy      <= 1'b1;
          r_bit_ready <= 1'b1;
        end
        STREAM: if (w_accept) begin
          if (w_b_cap) r_b_msb <= bit_b;
          if (w_last) begin
            r_beat <= '0;
            if (w_prod_done) begin
              r_prod      <= '0;
              r_state     <= OUT;
              r_bit_ready <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_prod <= r_prod + CNT_W'(1);
            end
          end else begin
            r_beat <= r_beat + CW'(1);
          end
        end
        OUT: if (out_ready) begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    bsm_lane #(
      .MAX_W(MAX_W),
      .ACC_W(ACC_W),
      .CW   (CW)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (w_clear),
      .i_beat_en(w_accept),
      .i_beat   (r_beat),
      .i_last   (w_last),
      .i_a_ext  (w_a_ext),
      .i_a_cap  (w_a_cap),
      .i_sign_a (r_sign_a),
      .i_sign_b (r_sign_b),
      .i_bit_a  (bits_a[gi]),
      .i_bit_b  (w_bit_b),
      .o_acc    (result[gi*ACC_W +: ACC_W]),
      .o_ovf    (overflow[gi])
    );
  end

  assign busy      = r_busy;
  assign bit_ready = r_bit_ready;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_bsm_mac_array.sv
// Self-checking bench for bsm_mac_array (MAX_W=8, ACC_W=17): table of single-product
// jobs plus hand sequences for accumulation, backpressure, abort, reset and saturation.
module tb_bsm_mac_array;

  localparam int MAX_W = 8;
  localparam int LANES = 4;
  localparam int ACC_W = 17;
  localparam int CNT_W = 8;
  localparam int WW    = $clog2(MAX_W + 1);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [WW-1:0]          wa, wb;
  logic                   sign_a, sign_b;
  logic [CNT_W-1:0]       acc_len;
  logic                   abort;
  logic                   busy;
  logic                   bit_valid;
  logic                   bit_ready;
  logic [LANES-1:0]       bits_a;
  logic                   bit_b;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*ACC_W-1:0] result;
  logic [LANES-1:0]       overflow;

  always #5 clk = ~clk;

  bsm_mac_array #(
    .MAX_W(MAX_W),
    .LANES(LANES),
    .ACC_W(ACC_W),
    .CNT_W(CNT_W)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .wa       (wa),
    .wb       (wb),
    .sign_a   (sign_a),
    .sign_b   (sign_b),
    .acc_len  (acc_len),
    .abort    (abort),
    .busy     (busy),
    .bit_valid(bit_valid),
    .bit_ready(bit_ready),
    .bits_a   (bits_a),
    .bit_b    (bit_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .overflow (overflow)
  );

  typedef struct {
    int wa, wb;
    bit sa, sb;
    int a[LANES];
    int b;
    int exp[LANES];
  } vec_t;

  typedef struct {
    int               res[LANES];
    logic [LANES-1:0] ovf;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[8];
  int   n_cmp = 0;
  int   n_bad = 0;

  int job_a[4][LANES];
  int job_b[4];
  int job_n, job_len, job_wa, job_wb, job_gap;
  bit job_sa, job_sb;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic longint lane_res(input int l);
    logic signed [ACC_W-1:0] v;
    v = result[l*ACC_W +: ACC_W];
    return longint'(v);
  endfunction

  function automatic int clampw(input int w);
    if (w == 0) return 1;
    if (w > MAX_W) return MAX_W;
    return w;
  endfunction

  function automatic vec_t mk(input int wa_i, input int wb_i, input bit sa_i, input bit sb_i,
                              input int a0, input int a1, input int a2, input int a3, input int b_i,
                              input int e0, input int e1, input int e2, input int e3);
    vec_t v;
    v.wa = wa_i; v.wb = wb_i; v.sa = sa_i; v.sb = sb_i; v.b = b_i;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    return v;
  endfunction

  task automatic load_vec(input vec_t v);
    job_wa = v.wa; job_wb = v.wb; job_sa = v.sa; job_sb = v.sb;
    job_n = 1; job_len = 1; job_gap = 2;
    for (int l = 0; l < LANES; l++) job_a[0][l] = v.a[l];
    job_b[0] = v.b;
  endtask

  task automatic start_job();
    wa = WW'(job_wa); wb = WW'(job_wb);
    sign_a = job_sa; sign_b = job_sb;
    acc_len = CNT_W'(job_len);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Beats k0..k1-1 of product p; columns beyond an operand's width carry junk.
  task automatic send_beats(input int p, input int k0, input int k1);
    int wac, wbc;
    wac = clampw(job_wa);
    wbc = clampw(job_wb);
    for (int k = k0; k < k1; k++) begin
      int g;
      int bv;
      g = int'($urandom_range(0, job_gap));
      repeat (g) begin
        bit_valid = 1'b0;
        bits_a = LANES'($urandom);
        bit_b  = 1'($urandom);
        @(posedge clk); #1;
      end
      for (int l = 0; l < LANES; l++) begin
        int av;
        av = job_a[p][l];
        bits_a[l] = (k < wac) ? av[k] : 1'($urandom);
      end
      bv = job_b[p];
      bit_b = (k < wbc) ? bv[k] : 1'($urandom);
      bit_valid = 1'b1;
      @(posedge clk); #1;
      bit_valid = 1'b0;
    end
  endtask

  task automatic stream_job();
    int maxw;
    maxw = (clampw(job_wa) > clampw(job_wb)) ? clampw(job_wa) : clampw(job_wb);
    check("bit_ready in STREAM", bit_ready, 1);
    for (int p = 0; p < job_n; p++) begin
      if (p == job_n - 1) begin
        send_beats(p, 0, maxw - 1);
        check("no early out_valid", out_valid, 0);
        send_beats(p, maxw - 1, maxw);
        check("out_valid latency", out_valid, 1);
      end else begin
        send_beats(p, 0, maxw);
      end
    end
  endtask

  task automatic collect(input int hold, input bit start_in_out);
    int   c;
    exp_t e;
    c = 0;
    while (!out_valid && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    check("out_valid seen", out_valid, 1);
    if (!out_valid) return;
    if (sb_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: result with no expected entry");
      return;
    end
    e = sb_q.pop_front();
    for (int l = 0; l < LANES; l++) check($sformatf("result lane %0d", l), lane_res(l), e.res[l]);
    check("overflow", overflow, e.ovf);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start = start_in_out && (h == 2);
      @(posedge clk); #1;
      start = 1'b0;
      check("held out_valid", out_valid, 1);
      check("held bit_ready", bit_ready, 0);
      check("held result", lane_res(0), e.res[0]);
    end
    out_ready = 1'b1;
    start = start_in_out;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start = 1'b0;
    check("idle after handshake busy", busy, 0);
    check("idle after handshake out_valid", out_valid, 0);
  endtask

  task automatic run_job(input exp_t e, input int hold, input bit start_in_out);
    sb_q.push_back(e);
    start_job();
    stream_job();
    collect(hold, start_in_out);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst = 1'b0; start = 1'b0; wa = '0; wb = '0; sign_a = 1'b0; sign_b = 1'b0;
    acc_len = '0; abort = 1'b0; bit_valid = 1'b0; bits_a = '0; bit_b = 1'b0; out_ready = 1'b0;
    job_gap = 2;

    vecs[0] = mk(4, 4, 0, 0,  13,   0,    7,  15,   11,   143,      0,    77,  165);
    vecs[1] = mk(4, 4, 1, 1,  -3,   0,    0,   0,    5,   -15,      0,     0,    0);
    vecs[2] = mk(3, 5, 1, 0,  -2,   3,   -4,   1,   19,   -38,     57,   -76,   19);
    vecs[3] = mk(0, 0, 0, 0,   1,   0,    1,   1,    1,     1,      0,     1,    1);
    vecs[4] = mk(15, 8, 0, 0, 255, 128,   1,   0,  200, 51000,  25600,   200,    0);
    vecs[5] = mk(8, 8, 1, 1, -128, 127, -128, -1, -128, 16384, -16256, 16384,  128);
    vecs[6] = mk(2, 6, 1, 1,  -2,   1,   -1,   0,  -32,    64,    -32,    32,    0);
    vecs[7] = mk(4, 4, 0, 1,  15,   8,    1,   0,   -1,   -15,     -8,    -1,    0);

    #23;
    check("reset busy", busy, 0);
    check("reset bit_ready", bit_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset overflow", overflow, 0);
    check("reset result", result == '0, 1);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      load_vec(vecs[i]);
      for (int l = 0; l < LANES; l++) e.res[l] = vecs[i].exp[l];
      e.ovf = '0;
      run_job(e, 0, 1'b0);
    end

    // acc_len of zero behaves as a single product
    load_vec(vecs[0]);
    job_len = 0;
    for (int l = 0; l < LANES; l++) e.res[l] = vecs[0].exp[l];
    e.ovf = '0;
    run_job(e, 0, 1'b0);

    // Backpressure with a start pulse during OUT and together with the handshake
    load_vec(vecs[1]);
    for (int l = 0; l < LANES; l++) e.res[l] = vecs[1].exp[l];
    e.ovf = '0;
    run_job(e, 5, 1'b1);

    // Signed dot product of three, gappy stream
    job_wa = 4; job_wb = 4; job_sa = 1; job_sb = 1; job_n = 3; job_len = 3; job_gap = 4;
    job_a[0] = '{2, 1, -8, 0};  job_b[0] = 3;
    job_a[1] = '{-1, -8, 7, 0}; job_b[1] = 4;
    job_a[2] = '{7, 0, -1, 7};  job_b[2] = 7;
    e.res = '{51, -29, -3, 49};
    e.ovf = '0;
    run_job(e, 0, 1'b0);

    // Abort mid-stream, then a clean job
    start_job();
    send_beats(0, 0, 4);
    send_beats(1, 0, 2);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort busy", busy, 0);
    check("abort bit_ready", bit_ready, 0);
    check("abort out_valid", out_valid, 0);
    load_vec(vecs[2]);
    for (int l = 0; l < LANES; l++) e.res[l] = vecs[2].exp[l];
    e.ovf = '0;
    run_job(e, 0, 1'b0);

    // Abort while a result is waiting
    load_vec(vecs[0]);
    start_job();
    stream_job();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort in OUT out_valid", out_valid, 0);
    check("abort in OUT busy", busy, 0);

    // Asynchronous reset in the middle of the second product
    job_wa = 4; job_wb = 4; job_sa = 1; job_sb = 1; job_n = 3; job_len = 3; job_gap = 1;
    job_a[0] = '{2, 1, -8, 0};  job_b[0] = 3;
    job_a[1] = '{-1, -8, 7, 0}; job_b[1] = 4;
    start_job();
    send_beats(0, 0, 4);
    send_beats(1, 0, 2);
    #2 rst = 1'b0;
    #1;
    check("mid reset busy", busy, 0);
    check("mid reset bit_ready", bit_ready, 0);
    check("mid reset result", result == '0, 1);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    load_vec(vecs[5]);
    for (int l = 0; l < LANES; l++) e.res[l] = vecs[5].exp[l];
    e.ovf = '0;
    run_job(e, 0, 1'b0);

    // Accumulator wrap or saturation: 2 x 255*255 in 17 bits
    job_wa = 8; job_wb = 8; job_sa = 0; job_sb = 0; job_n = 2; job_len = 2; job_gap = 1;
    job_a[0] = '{255, 1, 128, 0}; job_b[0] = 255;
    job_a[1] = '{255, 1, 128, 0}; job_b[1] = 255;
`ifdef BSM_MAC_SAT_EN
    e.res = '{65535, 510, 65280, 0};
    e.ovf = 4'b0001;
`else
    e.res = '{-1022, 510, 65280, 0};
    e.ovf = 4'b0000;
`endif
    run_job(e, 0, 1'b0);

    check("scoreboard drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
